// File: rtl/sequential_cla_subtractor_if.sv
// Request/result bundle for the sequential lookahead subtractor.
// Handshake: start is a request sampled only while the block is idle (busy=0, done=0);
// a, b are captured on the accepting edge; done pulses for one cycle when diff/flags
// hold the new result, which then stays stable until the next done or reset.
interface sequential_cla_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  diff, borrow, zero, neg, ovf, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow, zero, neg, ovf, busy, done
    );
endinterface

// File: rtl/sequential_cla_subtractor.sv
// Multi-cycle A - B computed as A + ~B + 1, resolving one SLICE-bit lookahead
// slice per clock; results and flags update atomically on completion.
module sequential_cla_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sequential_cla_subtractor_if.slave    bus,
    output logic [1:0]                    state_dbg
);
    localparam int NSL  = WIDTH / SLICE;
    localparam int CW   = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, shadow_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, zero_q, neg_q, ovf_q, busy_q, done_q;

    logic             accept, last;

    logic [SLICE-1:0] a_sl, nb_sl, g, p, s;
    logic [SLICE:0]   c;
    logic             pall, pp;
    logic [WIDTH-1:0] final_diff;
    int               base;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One slice of A + ~B + carry, carries expanded in lookahead form from g/p and carry_q.
    always_comb begin
        base  = int'(cnt_q) * SLICE;
        a_sl  = a_q[base +: SLICE];
        nb_sl = ~b_q[base +: SLICE];
        g     = a_sl & nb_sl;
        p     = a_sl ^ nb_sl;
        c     = '0;
        pall  = 1'b0;
        pp    = 1'b0;
        c[0]  = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            pall = carry_q;
            for (int j = 0; j <= i; j++) pall = pall & p[j];
            c[i+1] = pall;
            for (int j = 0; j <= i; j++) begin
                pp = g[j];
                for (int k = j + 1; k <= i; k++) pp = pp & p[k];
                c[i+1] = c[i+1] | pp;
            end
        end
        s = p ^ c[SLICE-1:0];
        final_diff = shadow_q;
        final_diff[base +: SLICE] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= 1'b1;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end
            if (state_q == S_CALC) begin
                shadow_q <= final_diff;
                carry_q  <= c[SLICE];
                cnt_q    <= last ? '0 : cnt_q + 1'b1;
            end
            // Final slice: publish difference and flags together.
            if (last) begin
                diff_q   <= final_diff;
                borrow_q <= ~c[SLICE];
                zero_q   <= (final_diff == '0);
                neg_q    <= final_diff[WIDTH-1];
                ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (final_diff[WIDTH-1] != a_q[WIDTH-1]);
                busy_q   <= 1'b0;
            end
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
    assign bus.neg    = neg_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_sequential_cla_subtractor.sv
// Bench for sequential_cla_subtractor: directed, handshake and random vectors
// checked against an arithmetic reference of A - B and its flags.
module tb_sequential_cla_subtractor;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    sequential_cla_subtractor_if #(.WIDTH(W)) bus ();

    sequential_cla_subtractor #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W+3:0] exp_q[$];

    // Reference result packed as {diff, borrow, zero, neg, ovf}.
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua, ub;
        int          sa, sb, r, lim;
        logic [W-1:0] d;
        logic bo, ze, ng, ov;
        ua  = a;
        ub  = b;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = sa - sb;
        lim = 1 << (W - 1);
        d   = a - b;
        bo  = (ua < ub);
        ze  = (d == '0);
        ng  = d[W-1];
        ov  = (r > lim - 1) || (r < -lim);
        return {d, bo, ze, ng, ov};
    endfunction

    function automatic logic [W+3:0] observed();
        return {bus.diff, bus.borrow, bus.zero, bus.neg, bus.ovf};
    endfunction

    // Issue one request, scramble operands after acceptance, wait (bounded) for done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W+3:0] obs, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        lat  = -1;
        bcnt = 0;
        obs  = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = i;
                obs = observed();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (observed() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected %h", observed(), {(W+4){1'b0}});
        end
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
        end
        n_cmp++;
        if (state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6] = '{16'h1234, 16'h0000, 16'h5555, 16'h8000, 16'h7FFF, 16'h1000};
        logic [W-1:0] tb[6] = '{16'h0034, 16'h0001, 16'h5555, 16'h0001, 16'hFFFF, 16'h0001};
        logic [W+3:0] te[6] = '{{16'h1200, 4'b0000}, {16'hFFFF, 4'b1010}, {16'h0000, 4'b0100},
                               {16'h7FFF, 4'b0001}, {16'h8000, 4'b1011}, {16'h0FFF, 4'b0000}};
        logic [W+3:0] obs;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], obs, lat, bcnt);
            n_cmp++;
            if (obs !== te[i]) begin
                n_err++;
                $display("FAIL directed_%0d: got %h expected %h", i, obs, te[i]);
            end
            n_cmp++;
            if (obs !== model(ta[i], tb[i])) begin
                n_err++;
                $display("FAIL directed_model_%0d: got %h expected %h", i, obs, model(ta[i], tb[i]));
            end
            n_cmp++;
            if (lat !== 5) begin
                n_err++;
                $display("FAIL latency_%0d: got %0d expected 5", i, lat);
            end
            n_cmp++;
            if (bcnt !== 4) begin
                n_err++;
                $display("FAIL busy_cycles_%0d: got %0d expected 4", i, bcnt);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W+3:0] obs;
        int lat, bcnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({observed(), bus.busy, bus.done} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h expected 0", {observed(), bus.busy, bus.done});
        end
        n_cmp++;
        if (state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL mid_reset_state: got %0d expected 0", state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_resume: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        do_op(16'h1234, 16'h0001, obs, lat, bcnt);
        n_cmp++;
        if (obs !== {16'h1233, 4'b0000} || lat !== 5) begin
            n_err++;
            $display("FAIL after_reset_op: got %h lat %0d expected %h lat 5", obs, lat, {16'h1233, 4'b0000});
        end
    endtask

    task automatic test_hold();
        logic [W+3:0] obs, prev, e;
        int lat, bcnt;
        bit seen;
        do_op(16'h4321, 16'h0021, prev, lat, bcnt);
        e = model(16'h1111, 16'h2222);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(posedge clk);
        #1 bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                obs  = observed();
                seen = 1'b1;
                n_cmp++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL hold_result: got %h expected %h", obs, e);
                end
                break;
            end
            if (bus.busy) begin
                n_cmp++;
                if (observed() !== prev) begin
                    n_err++;
                    $display("FAIL hold_prev_cycle_%0d: got %h expected %h", i, observed(), prev);
                end
            end
            bus.a = W'($urandom);
            bus.b = W'($urandom);
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL hold_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic test_back_to_back();
        logic [W+3:0] e;
        int ndone;
        ndone = 0;
        exp_q.delete();
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 56; c++) begin
            if (bus.done) begin
                ndone++;
                n_cmp++;
                if (((c - 5) % 6) != 0 || exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_timing: got done at cycle %0d expected cycle 5+6k", c);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (observed() !== e) begin
                        n_err++;
                        $display("FAIL b2b_result_%0d: got %h expected %h", ndone, observed(), e);
                    end
                end
            end
            if (c < 48) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                if (c % 6 == 0) exp_q.push_back(model(bus.a, bus.b));
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ndone !== 8 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results expected 8 (left %0d)", ndone, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [W+3:0] obs, e;
        int lat, bcnt;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
            e = model(a, b);
            do_op(a, b, obs, lat, bcnt);
            n_cmp++;
            if (obs !== e || lat !== 5) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h: got %h lat %0d expected %h lat 5", i, a, b, obs, lat, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_op();
        test_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
